// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - angle format constants, saturation helper and phase_gen FSM states
// Shared by phase_gen and the CORDIC pipeline; angles are signed Q.FRAC_BITS radians.
package cordic_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 14;

  // round(pi * 2^FRAC_BITS); carried at DATA_WIDTH+1 bits so sums never overflow
  localparam logic signed [DATA_WIDTH:0] PI     = 33'sd51472;
  localparam logic signed [DATA_WIDTH:0] TWO_PI = 33'sd102944;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } phase_gen_state_t;

  function automatic logic signed [DATA_WIDTH:0] QUANTIZE(
    input logic signed [DATA_WIDTH:0] x,
    input logic signed [DATA_WIDTH:0] lo,
    input logic signed [DATA_WIDTH:0] hi
  );
    if (x < lo)      return lo;
    else if (x > hi) return hi;
    else             return x;
  endfunction

endpackage

// File: rtl/phase_wrap.sv
// rtl/phase_wrap.sv - combinational phase clamp or single-correction wrap into [-PI, PI)
// clamp_mode_i=1 clamps phase_i to [-PI, PI-1]; otherwise returns wrap(phase_i + step_i).
module phase_wrap
  import cordic_pkg::*;
(
  input  logic                         clamp_mode_i,
  input  logic signed [DATA_WIDTH-1:0] phase_i,
  input  logic signed [DATA_WIDTH-1:0] step_i,
  output logic signed [DATA_WIDTH-1:0] phase_o
);

  logic signed [DATA_WIDTH:0] phase_ext;
  logic signed [DATA_WIDTH:0] sum;
  logic signed [DATA_WIDTH:0] result;

  assign phase_ext = {phase_i[DATA_WIDTH-1], phase_i};

  // One correction suffices: phase is already in range and |step| <= PI.
  always_comb begin
    sum = phase_ext + {step_i[DATA_WIDTH-1], step_i};
    if (clamp_mode_i)     result = QUANTIZE(phase_ext, -PI, PI - 33'sd1);
    else if (sum >= PI)   result = sum - TWO_PI;
    else if (sum < -PI)   result = sum + TWO_PI;
    else                  result = sum;
  end

  assign phase_o = result[DATA_WIDTH-1:0];

endmodule

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - NCO-style angle generator feeding the CORDIC angle FIFO
// Optional build macro PHASE_GEN_DITHER_EN adds LFSR dither to out_din.
module phase_gen
  import cordic_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic signed [DATA_WIDTH-1:0] init_phase,
  input  logic signed [DATA_WIDTH-1:0] step,
  input  logic        [CNT_WIDTH-1:0]  count,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic signed [DATA_WIDTH-1:0] out_din,
  output logic                         busy,
  output logic                         done
);

  phase_gen_state_t             state_q, state_d;
  logic signed [DATA_WIDTH-1:0] phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] step_q, step_d;
  logic        [CNT_WIDTH-1:0]  rem_q, rem_d;

  logic signed [DATA_WIDTH-1:0] phase_next;
  logic signed [DATA_WIDTH-1:0] init_clamped;
  logic signed [DATA_WIDTH:0]   step_sat;

  phase_wrap u_acc_wrap (
    .clamp_mode_i(1'b0),
    .phase_i     (phase_q),
    .step_i      (step_q),
    .phase_o     (phase_next)
  );

  phase_wrap u_init_clamp (
    .clamp_mode_i(1'b1),
    .phase_i     (init_phase),
    .step_i      ('0),
    .phase_o     (init_clamped)
  );

  assign step_sat = QUANTIZE({step[DATA_WIDTH-1], step}, -PI, PI);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    rem_d     = rem_q;
    out_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d  = step_sat[DATA_WIDTH-1:0];
          phase_d = init_clamped;
          rem_d   = count;
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // stop takes priority so an aborted run never pushes a partial write
        if (stop) begin
          state_d = DONE;
        end else if ((rem_q != '0) && !out_full) begin
          out_wr_en = 1'b1;
          phase_d   = phase_next;
          rem_d     = rem_q - 1'b1;
          if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      step_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

`ifdef PHASE_GEN_DITHER_EN
  logic [15:0]                lfsr_q, lfsr_d;
  logic signed [DATA_WIDTH:0] dith_sum;
  logic signed [DATA_WIDTH:0] dith_sat;

  // Galois form of x^16+x^14+x^13+x^11+1, stepped once per FIFO write
  assign lfsr_d = out_wr_en ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign dith_sum = {phase_q[DATA_WIDTH-1], phase_q} + {{(DATA_WIDTH-1){1'b0}}, lfsr_q[1:0]};
  assign dith_sat = (dith_sum > PI - 33'sd1) ? PI - 33'sd1 : dith_sum;
  assign out_din  = (state_q == RUN) ? dith_sat[DATA_WIDTH-1:0] : phase_q;
`else
  assign out_din = phase_q;
`endif

endmodule

// File: tb/tb_phase_gen.sv
// tb/tb_phase_gen.sv - self-checking bench for phase_gen against a modular-arithmetic angle model
module tb_phase_gen;

  localparam longint PI_M  = 51472;
  localparam longint TWO_M = 102944;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic signed [31:0] init_phase = '0;
  logic signed [31:0] step = '0;
  logic        [15:0] count = '0;
  logic               out_full = 1'b0;
  logic               out_wr_en;
  logic signed [31:0] out_din;
  logic               busy;
  logic               done;

  phase_gen dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .init_phase(init_phase),
    .step      (step),
    .count     (count),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int wq[$];
  int wr_cyc[$];
  int exp_q[$];
  int done_cnt, done_cyc, stall_cnt, stop_cyc;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (out_wr_en) begin
      wq.push_back(out_din);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !done && out_full) stall_cnt++;
  end

  // Reference: angles live on a circle of circumference 2*PI, mapped to [-PI, PI)
  function automatic longint wrap_m(input longint x);
    longint m;
    m = (x + PI_M) % TWO_M;
    if (m < 0) m += TWO_M;
    return m - PI_M;
  endfunction

  function automatic longint clamp_m(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  task automatic make_exp(input int init, input int stp, input int n);
    longint p, s;
    exp_q.delete();
    p = clamp_m(init, -PI_M, PI_M - 1);
    s = clamp_m(stp, -PI_M, PI_M);
    repeat (n) begin
      exp_q.push_back(int'(p));
      p = wrap_m(p + s);
    end
  endtask

  // mode: 0 never full, 1 random full, 2 full for 5 cycles after the 3rd write
  task automatic run_cmd(input int init, input int stp, input int n, input int mode,
                         input int stop_at, input bit inject, output int s_cyc, output bit ok);
    int stalled;
    bit stopped;
    wq.delete();
    wr_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    stall_cnt = 0;
    stop_cyc  = -1;
    stalled   = 0;
    stopped   = 0;
    ok        = 0;
    @(posedge clock); #1;
    start = 1'b1; init_phase = init; step = stp; count = 16'(n); out_full = 1'b0;
    s_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (mode)
        1:       out_full = ($urandom_range(0, 3) == 0);
        2: begin
          out_full = (wq.size() == 3 && stalled < 5);
          if (out_full) stalled++;
        end
        default: out_full = 1'b0;
      endcase
      if (stop_at >= 0 && !stopped && wq.size() == stop_at) begin
        stop = 1'b1; stopped = 1; stop_cyc = cyc;
      end else begin
        stop = 1'b0;
      end
      if (inject && i == 2) begin
        start = 1'b1; init_phase = 777; step = 5; count = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    out_full = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_tests++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0b want 0", out_wr_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (out_din !== 32'sd0) begin n_fail++; $display("FAIL reset_din got %0d want 0", out_din); end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int s; bit ok;
    int golden[8] = '{0, 12868, 25736, 38604, -51472, -38604, -25736, -12868};
    run_cmd(0, 12868, 8, 0, -1, 0, s, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got 0 want 1"); end
    n_tests++; if (wq.size() != 8) begin n_fail++; $display("FAIL basic_count got %0d want 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      n_tests++;
      if (wq[i] !== golden[i]) begin n_fail++; $display("FAIL basic_sample[%0d] got %0d want %0d", i, wq[i], golden[i]); end
    end
    if (wr_cyc.size() > 0) begin
      n_tests++; if (wr_cyc[0] != s + 1) begin n_fail++; $display("FAIL basic_first_write got %0d want %0d", wr_cyc[0], s + 1); end
    end
    n_tests++; if (done_cyc != s + 9) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, s + 9); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_stall();
    int s; bit ok;
    make_exp(0, 12868, 8);
    run_cmd(0, 12868, 8, 2, -1, 0, s, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got 0 want 1"); end
    n_tests++; if (wq.size() != 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      n_tests++;
      if (wq[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_sample[%0d] got %0d want %0d", i, wq[i], exp_q[i]); end
    end
    n_tests++; if (done_cyc != s + 14) begin n_fail++; $display("FAIL stall_done_cycle got %0d want %0d", done_cyc, s + 14); end
  endtask

  task automatic test_count_zero();
    int s; bit ok;
    run_cmd(1234, 999, 0, 0, -1, 0, s, ok);
    n_tests++; if (wq.size() != 0) begin n_fail++; $display("FAIL zero_writes got %0d want 0", wq.size()); end
    n_tests++; if (done_cyc != s + 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc, s + 1); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt); end
    @(negedge clock);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_neg_step();
    int s; bit ok;
    int golden[6] = '{0, -12868, -25736, -38604, -51472, 38604};
    run_cmd(0, -12868, 6, 0, -1, 0, s, ok);
    n_tests++; if (wq.size() != 6) begin n_fail++; $display("FAIL neg_count got %0d want 6", wq.size()); end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      n_tests++;
      if (wq[i] !== golden[i]) begin n_fail++; $display("FAIL neg_sample[%0d] got %0d want %0d", i, wq[i], golden[i]); end
    end
  endtask

  task automatic test_clamp_restart();
    int s; bit ok;
    make_exp(0, 100000, 6);
    run_cmd(0, 100000, 6, 0, -1, 1, s, ok);
    repeat (6) @(negedge clock);
    n_tests++; if (wq.size() != 6) begin n_fail++; $display("FAIL clamp_count got %0d want 6", wq.size()); end
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      n_tests++;
      if (wq[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_sample[%0d] got %0d want %0d", i, wq[i], exp_q[i]); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL clamp_done_pulses got %0d want 1", done_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clamp_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_stop();
    int s; bit ok;
    make_exp(-40000, 9000, 20);
    run_cmd(-40000, 9000, 20, 0, 5, 0, s, ok);
    n_tests++; if (wq.size() != 5) begin n_fail++; $display("FAIL stop_writes got %0d want 5", wq.size()); end
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      n_tests++;
      if (wq[i] !== exp_q[i]) begin n_fail++; $display("FAIL stop_sample[%0d] got %0d want %0d", i, wq[i], exp_q[i]); end
    end
    n_tests++; if (done_cyc != stop_cyc + 1) begin n_fail++; $display("FAIL stop_done_cycle got %0d want %0d", done_cyc, stop_cyc + 1); end
  endtask

  task automatic test_random();
    int s, init, stp, n; bit ok;
    for (int it = 0; it < 8; it++) begin
      init = int'($urandom_range(0, 6 * 51472)) - 3 * 51472;
      stp  = int'($urandom_range(0, 6 * 51472)) - 3 * 51472;
      n    = int'($urandom_range(1, 20));
      make_exp(init, stp, n);
      run_cmd(init, stp, n, 1, -1, 0, s, ok);
      n_tests++; if (wq.size() != n) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", it, wq.size(), n); end
      for (int i = 0; i < n && i < wq.size(); i++) begin
        n_tests++;
        if (wq[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_sample[%0d] got %0d want %0d", it, i, wq[i], exp_q[i]); end
      end
      n_tests++;
      if (done_cyc != s + 1 + n + stall_cnt) begin
        n_fail++; $display("FAIL rand%0d_done_cycle got %0d want %0d", it, done_cyc, s + 1 + n + stall_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    start = 1'b1; init_phase = 5000; step = 1000; count = 16'd30;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    n_tests++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL areset_wr_en got %0b want 0", out_wr_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %0b want 0", busy); end
    n_tests++; if (out_din !== 32'sd0) begin n_fail++; $display("FAIL areset_din got %0d want 0", out_din); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_after_busy got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_count_zero();
    test_neg_step();
    test_clamp_restart();
    test_stop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
